// File: rtl/optical_trap_scheduler_if.sv
// Control, configuration and status bundle between a sequencing host and optical_trap_scheduler.
interface optical_trap_scheduler_if #(
  parameter int PERIOD_WIDTH = 24,
  parameter int HOLD_WIDTH   = 18,
  parameter int COUNT_WIDTH  = 16
);
  logic                    enable_i;
  logic                    mode_i;
  logic                    start_i;
  logic                    abort_i;
  logic                    ext_trig_i;
  logic [PERIOD_WIDTH-1:0] period_cycles_i;
  logic [HOLD_WIDTH-1:0]   holdoff_cycles_i;
  logic [COUNT_WIDTH-1:0]  burst_count_i;
  logic                    trig_o;
  logic                    trap_enable_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    missed_o;
  logic [COUNT_WIDTH-1:0]  pulse_count_o;

  modport master (
    output enable_i, mode_i, start_i, abort_i, ext_trig_i,
           period_cycles_i, holdoff_cycles_i, burst_count_i,
    input  trig_o, trap_enable_o, busy_o, done_o, missed_o, pulse_count_o
  );

  modport slave (
    input  enable_i, mode_i, start_i, abort_i, ext_trig_i,
           period_cycles_i, holdoff_cycles_i, burst_count_i,
    output trig_o, trap_enable_o, busy_o, done_o, missed_o, pulse_count_o
  );
endinterface

// File: rtl/optical_trap_scheduler.sv
// Trap-release scheduler: external-edge or periodic trigger pulses with burst, holdoff and abort.
// Define OPT_TRAP_SCHED_TRIG_SYNC_EN to put a 2-FF synchronizer on ext_trig_i.
//
// state   | meaning
// IDLE    | waiting for start
// ARMED   | waiting for an ext edge or period tick
// FIRE    | trig_o high, count updated
// HOLDOFF | dead time after a pulse; events here are dropped and flagged
// DONE    | burst complete, done_o high
module optical_trap_scheduler #(
  parameter int PERIOD_WIDTH = 24,
  parameter int HOLD_WIDTH   = 18,
  parameter int COUNT_WIDTH  = 16
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  optical_trap_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FIRE,
    S_HOLDOFF,
    S_DONE
  } state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] period_cnt;
  logic [PERIOD_WIDTH-1:0] period_reload;
  logic [HOLD_WIDTH-1:0]   hold_cnt;
  logic [HOLD_WIDTH-1:0]   hold_load;
  logic [COUNT_WIDTH-1:0]  count_inc;
  logic                    mode_q;
  logic                    mode_chg;
  logic                    ext_src;
  logic                    ext_prev;
  logic                    ext_edge;
  logic                    busy_st;
  logic                    tick;
  logic                    event_hit;

`ifdef OPT_TRAP_SCHED_TRIG_SYNC_EN
  logic [1:0] ext_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ext_sync <= '0;
    else         ext_sync <= {ext_sync[0], bus.ext_trig_i};
  end

  assign ext_src = ext_sync[1];
`else
  assign ext_src = bus.ext_trig_i;
`endif

  assign ext_edge  = ext_src & ~ext_prev;
  assign busy_st   = (state == S_ARMED) || (state == S_FIRE) || (state == S_HOLDOFF);
  assign mode_chg  = (bus.mode_i != mode_q);
  assign tick      = busy_st && mode_q && (period_cnt == '0);
  assign event_hit = mode_q ? tick : ext_edge;

  // Reload of period-1 gives one tick every max(period, 2) cycles.
  assign period_reload = (bus.period_cycles_i < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(1)
                         : bus.period_cycles_i - PERIOD_WIDTH'(1);
  assign hold_load     = (bus.holdoff_cycles_i == '0) ? '0
                         : bus.holdoff_cycles_i - HOLD_WIDTH'(1);
  assign count_inc     = (&bus.pulse_count_o) ? bus.pulse_count_o
                         : bus.pulse_count_o + COUNT_WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ext_prev   <= 1'b0;
      period_cnt <= '0;
    end else begin
      ext_prev <= ext_src;
      if (!busy_st || mode_chg) period_cnt <= '0;
      else if (period_cnt == '0) period_cnt <= period_reload;
      else                       period_cnt <= period_cnt - PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= S_IDLE;
      hold_cnt          <= '0;
      mode_q            <= 1'b0;
      bus.trig_o        <= 1'b0;
      bus.trap_enable_o <= 1'b0;
      bus.busy_o        <= 1'b0;
      bus.done_o        <= 1'b0;
      bus.missed_o      <= 1'b0;
      bus.pulse_count_o <= '0;
    end else begin
      bus.trap_enable_o <= bus.enable_i;
      mode_q            <= bus.mode_i;
      bus.trig_o        <= 1'b0;
      bus.done_o        <= 1'b0;
      if (((state == S_FIRE) || (state == S_HOLDOFF)) && event_hit)
        bus.missed_o <= 1'b1;

      if (!bus.enable_i || bus.abort_i) begin
        state      <= S_IDLE;
        bus.busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start_i) begin
              state             <= S_ARMED;
              bus.busy_o        <= 1'b1;
              bus.pulse_count_o <= '0;
              bus.missed_o      <= 1'b0;
            end
          end
          S_ARMED: begin
            if (event_hit) begin
              state             <= S_FIRE;
              bus.trig_o        <= 1'b1;
              bus.pulse_count_o <= count_inc;
            end
          end
          S_FIRE: begin
            if ((bus.burst_count_i != '0) && (bus.pulse_count_o == bus.burst_count_i)) begin
              state       <= S_DONE;
              bus.done_o  <= 1'b1;
              bus.busy_o  <= 1'b0;
            end else begin
              state    <= S_HOLDOFF;
              hold_cnt <= hold_load;
            end
          end
          S_HOLDOFF: begin
            if (hold_cnt == '0) state    <= S_ARMED;
            else                hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_optical_trap_scheduler.sv
// Scoreboard bench for optical_trap_scheduler: expected trig/done cycles queued at stimulus time.
`timescale 1ns/1ps
module tb_optical_trap_scheduler;
`ifdef OPT_TRAP_SCHED_TRIG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_q[$];
  int   trig_log[$];
  int   done_log[$];

  optical_trap_scheduler_if bus ();

  optical_trap_scheduler dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.trig_o) trig_log.push_back(cyc);
    if (bus.done_o) done_log.push_back(cyc);
  end

  task automatic clear_logs();
    exp_q.delete();
    trig_log.delete();
    done_log.delete();
  endtask

  task automatic do_start(output int c);
    @(negedge clk);
    bus.start_i = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.trig_o !== 1'b0) begin n_bad++; $display("FAIL rst_trig: got %b want 0", bus.trig_o); end
    n_cmp++; if (bus.trap_enable_o !== 1'b0) begin n_bad++; $display("FAIL rst_trap_en: got %b want 0", bus.trap_enable_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", bus.done_o); end
    n_cmp++; if (bus.missed_o !== 1'b0) begin n_bad++; $display("FAIL rst_missed: got %b want 0", bus.missed_o); end
    n_cmp++; if (bus.pulse_count_o !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", bus.pulse_count_o); end
    rst_n = 1'b1;
    bus.enable_i = 1'b1;
    clear_logs();
    repeat (100) @(negedge clk);
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL idle_trig: got %0d pulses want 0", trig_log.size()); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.trap_enable_o !== 1'b1) begin n_bad++; $display("FAIL idle_trap_en: got %b want 1", bus.trap_enable_o); end
  endtask

  task automatic test_ext_burst();
    int c, e, o, last;
    bus.mode_i = 1'b0; bus.burst_count_i = 16'd3; bus.holdoff_cycles_i = 18'd10; bus.period_cycles_i = 24'd0;
    clear_logs();
    do_start(c);
    repeat (4) @(negedge clk);
    last = 0;
    for (int i = 0; i < 3; i++) begin
      bus.ext_trig_i = 1'b1;
      last = cyc + LAT;
      exp_q.push_back(last);
      repeat (5) @(negedge clk);
      bus.ext_trig_i = 1'b0;
      repeat (15) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (trig_log.size() == 0) begin n_bad++; $display("FAIL ext_trig: got none want cycle %0d", e); end
      else begin
        o = trig_log.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL ext_trig: got cycle %0d want %0d", o, e); end
      end
    end
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL ext_extra: got %0d extra pulses want 0", trig_log.size()); end
    n_cmp++;
    if (done_log.size() != 1) begin n_bad++; $display("FAIL ext_done: got %0d done pulses want 1", done_log.size()); end
    else if (done_log[0] !== last + 1) begin n_bad++; $display("FAIL ext_done: got cycle %0d want %0d", done_log[0], last + 1); end
    n_cmp++; if (bus.pulse_count_o !== 16'd3) begin n_bad++; $display("FAIL ext_count: got %0d want 3", bus.pulse_count_o); end
    n_cmp++; if (bus.missed_o !== 1'b0) begin n_bad++; $display("FAIL ext_missed: got %b want 0", bus.missed_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL ext_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_periodic();
    int c, e, o;
    bus.mode_i = 1'b1; bus.period_cycles_i = 24'd100; bus.holdoff_cycles_i = 18'd5; bus.burst_count_i = 16'd0;
    clear_logs();
    do_start(c);
    for (int i = 0; i < 4; i++) exp_q.push_back(c + 2 + 100 * i);
    repeat (348) @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL per_abort_busy: got %b want 0", bus.busy_o); end
    repeat (80) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (trig_log.size() == 0) begin n_bad++; $display("FAIL per_trig: got none want cycle %0d", e); end
      else begin
        o = trig_log.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL per_trig: got cycle %0d want %0d", o, e); end
      end
    end
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL per_extra: got %0d extra pulses want 0", trig_log.size()); end
    n_cmp++; if (done_log.size() != 0) begin n_bad++; $display("FAIL per_done: got %0d done pulses want 0", done_log.size()); end
    n_cmp++; if (bus.pulse_count_o !== 16'd4) begin n_bad++; $display("FAIL per_count: got %0d want 4", bus.pulse_count_o); end
  endtask

  task automatic test_missed();
    int c, e, o;
    bus.mode_i = 1'b0; bus.holdoff_cycles_i = 18'd50; bus.burst_count_i = 16'd0;
    clear_logs();
    do_start(c);
    repeat (3) @(negedge clk);
    bus.ext_trig_i = 1'b1;
    exp_q.push_back(cyc + LAT);
    repeat (3) @(negedge clk);
    bus.ext_trig_i = 1'b0;
    repeat (7) @(negedge clk);
    bus.ext_trig_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.ext_trig_i = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (bus.missed_o !== 1'b1) begin n_bad++; $display("FAIL miss_set: got %b want 1", bus.missed_o); end
    repeat (60) @(negedge clk);
    n_cmp++; if (bus.missed_o !== 1'b1) begin n_bad++; $display("FAIL miss_sticky: got %b want 1", bus.missed_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (trig_log.size() == 0) begin n_bad++; $display("FAIL miss_trig: got none want cycle %0d", e); end
      else begin
        o = trig_log.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL miss_trig: got cycle %0d want %0d", o, e); end
      end
    end
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL miss_extra: got %0d extra pulses want 0", trig_log.size()); end
    do_abort();
    n_cmp++; if (bus.missed_o !== 1'b1) begin n_bad++; $display("FAIL miss_idle: got %b want 1", bus.missed_o); end
    do_start(c);
    n_cmp++; if (bus.missed_o !== 1'b0) begin n_bad++; $display("FAIL miss_clear: got %b want 0", bus.missed_o); end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL miss_rearm: got %b want 1", bus.busy_o); end
    do_abort();
  endtask

  task automatic test_disable();
    int c, e, o;
    bus.mode_i = 1'b0; bus.holdoff_cycles_i = 18'd30; bus.burst_count_i = 16'd0;
    clear_logs();
    do_start(c);
    repeat (3) @(negedge clk);
    bus.ext_trig_i = 1'b1;
    exp_q.push_back(cyc + LAT);
    repeat (2) @(negedge clk);
    bus.ext_trig_i = 1'b0;
    repeat (10) @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.trap_enable_o !== 1'b0) begin n_bad++; $display("FAIL dis_trap_en: got %b want 0", bus.trap_enable_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL dis_busy: got %b want 0", bus.busy_o); end
    repeat (3) @(negedge clk);
    bus.ext_trig_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.ext_trig_i = 1'b0;
    repeat (40) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (trig_log.size() == 0) begin n_bad++; $display("FAIL dis_trig: got none want cycle %0d", e); end
      else begin
        o = trig_log.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL dis_trig: got cycle %0d want %0d", o, e); end
      end
    end
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL dis_extra: got %0d extra pulses want 0", trig_log.size()); end
    n_cmp++; if (done_log.size() != 0) begin n_bad++; $display("FAIL dis_done: got %0d done pulses want 0", done_log.size()); end
    bus.enable_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    int c, e, o, d;
    // Holdoff 0: an edge 2 cycles after the pulse lands in the 1-cycle HOLDOFF, 3 cycles after is accepted.
    bus.mode_i = 1'b0; bus.holdoff_cycles_i = 18'd0; bus.burst_count_i = 16'd0;
    for (int gap = 2; gap <= 3; gap++) begin
      clear_logs();
      do_start(c);
      repeat (2) @(negedge clk);
      bus.ext_trig_i = 1'b1;
      e = cyc;
      exp_q.push_back(e + LAT);
      if (gap == 3) exp_q.push_back(e + 3 + LAT);
      @(negedge clk);
      bus.ext_trig_i = 1'b0;
      repeat (gap - 1) @(negedge clk);
      bus.ext_trig_i = 1'b1;
      @(negedge clk);
      bus.ext_trig_i = 1'b0;
      repeat (8) @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (trig_log.size() == 0) begin n_bad++; $display("FAIL hold0_trig gap%0d: got none want cycle %0d", gap, e); end
        else begin
          o = trig_log.pop_front();
          if (o !== e) begin n_bad++; $display("FAIL hold0_trig gap%0d: got cycle %0d want %0d", gap, o, e); end
        end
      end
      n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL hold0_extra gap%0d: got %0d extra want 0", gap, trig_log.size()); end
      n_cmp++; if (bus.missed_o !== (gap == 2)) begin n_bad++; $display("FAIL hold0_missed gap%0d: got %b want %b", gap, bus.missed_o, gap == 2); end
      do_abort();
    end

    // start and abort together in IDLE
    bus.mode_i = 1'b1; bus.period_cycles_i = 24'd5;
    clear_logs();
    @(negedge clk);
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL start_abort_busy: got %b want 0", bus.busy_o); end
    repeat (20) @(negedge clk);
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL start_abort_trig: got %0d pulses want 0", trig_log.size()); end

    // burst of one
    bus.mode_i = 1'b0; bus.holdoff_cycles_i = 18'd10; bus.burst_count_i = 16'd1;
    clear_logs();
    do_start(c);
    repeat (2) @(negedge clk);
    bus.ext_trig_i = 1'b1;
    d = cyc + LAT + 1;
    exp_q.push_back(cyc + LAT);
    repeat (2) @(negedge clk);
    bus.ext_trig_i = 1'b0;
    repeat (10) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (trig_log.size() == 0) begin n_bad++; $display("FAIL burst1_trig: got none want cycle %0d", e); end
      else begin
        o = trig_log.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL burst1_trig: got cycle %0d want %0d", o, e); end
      end
    end
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL burst1_extra: got %0d extra want 0", trig_log.size()); end
    n_cmp++;
    if (done_log.size() != 1) begin n_bad++; $display("FAIL burst1_done: got %0d done pulses want 1", done_log.size()); end
    else if (done_log[0] !== d) begin n_bad++; $display("FAIL burst1_done: got cycle %0d want %0d", done_log[0], d); end
    n_cmp++; if (bus.pulse_count_o !== 16'd1) begin n_bad++; $display("FAIL burst1_count: got %0d want 1", bus.pulse_count_o); end

    // period 0 ticks every 2 cycles; the tick inside the 1-cycle HOLDOFF is dropped
    bus.mode_i = 1'b1; bus.period_cycles_i = 24'd0; bus.holdoff_cycles_i = 18'd0; bus.burst_count_i = 16'd2;
    clear_logs();
    do_start(c);
    exp_q.push_back(c + 2);
    exp_q.push_back(c + 6);
    repeat (15) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (trig_log.size() == 0) begin n_bad++; $display("FAIL per0_trig: got none want cycle %0d", e); end
      else begin
        o = trig_log.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL per0_trig: got cycle %0d want %0d", o, e); end
      end
    end
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL per0_extra: got %0d extra want 0", trig_log.size()); end
    n_cmp++;
    if (done_log.size() != 1) begin n_bad++; $display("FAIL per0_done: got %0d done pulses want 1", done_log.size()); end
    else if (done_log[0] !== c + 7) begin n_bad++; $display("FAIL per0_done: got cycle %0d want %0d", done_log[0], c + 7); end
    n_cmp++; if (bus.missed_o !== 1'b1) begin n_bad++; $display("FAIL per0_missed: got %b want 1", bus.missed_o); end
    n_cmp++; if (bus.pulse_count_o !== 16'd2) begin n_bad++; $display("FAIL per0_count: got %0d want 2", bus.pulse_count_o); end
  endtask

  task automatic test_reset_mid_burst();
    int c, e, o;
    bus.mode_i = 1'b1; bus.period_cycles_i = 24'd10; bus.holdoff_cycles_i = 18'd2; bus.burst_count_i = 16'd0;
    clear_logs();
    do_start(c);
    exp_q.push_back(c + 2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.pulse_count_o !== 16'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", bus.pulse_count_o); end
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (trig_log.size() == 0) begin n_bad++; $display("FAIL rstmid_trig: got none want cycle %0d", e); end
      else begin
        o = trig_log.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL rstmid_trig: got cycle %0d want %0d", o, e); end
      end
    end
    n_cmp++; if (trig_log.size() != 0) begin n_bad++; $display("FAIL rstmid_extra: got %0d extra want 0", trig_log.size()); end
  endtask

  initial begin
    bus.enable_i = 1'b0;
    bus.mode_i = 1'b0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.ext_trig_i = 1'b0;
    bus.period_cycles_i = '0;
    bus.holdoff_cycles_i = '0;
    bus.burst_count_i = '0;
    test_reset();
    test_ext_burst();
    test_periodic();
    test_missed();
    test_disable();
    test_boundaries();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
